// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder slice per clock
// The slice is two half_adder cells plus an OR; a carry flop closes the loop.

module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] w_acc_next;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;
   logic             w_s0;
   logic             w_c0;
   logic             w_s;
   logic             w_c1;
   logic             w_c;
   logic             w_last;
   logic             w_accept;

   half_adder u_ha0 (.i_a(r_sa[0]), .i_b(r_sb[0]),   .o_s(w_s0), .o_c(w_c0));
   half_adder u_ha1 (.i_a(w_s0),    .i_b(r_carry),   .o_s(w_s),  .o_c(w_c1));

   assign w_c      = w_c0 | w_c1;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   // DONE accepts a new start just like IDLE, giving back-to-back operation
   assign w_accept = start && (r_state != S_SHIFT);

   generate
      if (WIDTH == 1) begin : g_acc_one
         assign w_acc_next = w_s;
      end else begin : g_acc_many
         assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_cnt   <= '0;
         end else if (r_state == S_SHIFT) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_acc   <= w_acc_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum  <= w_acc_next;
               r_cout <= w_c;
            end
         end
      end
   end

   assign busy = (r_state == S_SHIFT);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1)

module tb_serial_adder;
   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   int tests;
   int fails;
   logic [8:0] exp_q[$];
   logic [1:0] exp1_q[$];

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitors: pop one expectation per done pulse
   always @(negedge clk) begin
      if (!rst && done) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL w8_unexpected_done: got sum=%0h cout=%0b expected no done", sum, cout);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({cout, sum} !== e) begin
               fails++;
               $display("FAIL w8_result: got %0h expected %0h", {cout, sum}, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done1) begin
         tests++;
         if (exp1_q.size() == 0) begin
            fails++;
            $display("FAIL w1_unexpected_done: got sum=%0b cout=%0b expected no done", sum1, cout1);
         end else begin
            logic [1:0] e;
            e = exp1_q.pop_front();
            if ({cout1, sum1} !== e) begin
               fails++;
               $display("FAIL w1_result: got %0h expected %0h", {cout1, sum1}, e);
            end
         end
      end
   end

   // Issue a start accepted at the next edge; returns negedges until done (0 = timeout)
   task automatic run_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [8:0] expv, output int n_done, output int n_busy);
      n_done = 0;
      n_busy = 0;
      a = ia; b = ib; cin = ic; start = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) n_busy++;
         if (done) begin
            n_done = i;
            break;
         end
      end
   endtask

   initial begin
      int nd;
      int nb;
      int done_cnt;
      int t_prev;
      int seen;
      tests = 0; fails = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {busy, done, sum, cout}, 11'h0);
      rst = 1'b0;
      @(negedge clk);

      // FF + 01 + 0 -> 0x100
      run_add(8'hFF, 8'h01, 1'b0, 9'h100, nd, nb);
      check("t1_done_latency", nd, 9);
      check("t1_busy_cycles", nb, 8);
      @(negedge clk);
      check("t1_done_one_cycle", done, 1'b0);

      // 5A + 33 + 1 -> 0x08E; previous result must hold during SHIFT
      a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
      exp_q.push_back(9'h08E);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("t2_busy_mid", busy, 1'b1);
      check("t2_sum_hold", sum, 8'h00);
      check("t2_cout_hold", cout, 1'b1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("t2_done_seen", seen, 1);

      // start held high: back-to-back acceptance, done every 9 cycles
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      repeat (3) exp_q.push_back(9'h002);
      done_cnt = 0; t_prev = 0;
      for (int i = 1; i <= 40 && done_cnt < 3; i++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cnt > 1) check("t3_done_period", i - t_prev, 9);
            t_prev = i;
            if (done_cnt == 3) start = 1'b0;
         end
      end
      check("t3_done_count", done_cnt, 3);
      repeat (2) @(negedge clk);

      // reset at the 4th SHIFT edge aborts the operation
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t4_abort_outputs", {busy, done, sum, cout}, 11'h0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      check("t4_no_done_after_abort", seen, 0);
      run_add(8'h10, 8'h20, 1'b0, 9'h030, nd, nb);
      check("t4_post_reset_latency", nd, 9);

      // operands changed right after acceptance must not affect the result
      a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
      exp_q.push_back(9'h007);
      @(posedge clk);
      #1 start = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b1;
      seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            check("t5_latency", i, 9);
         end
      end
      check("t5_done_seen", seen, 1);

      // WIDTH=1: 1 + 1 + 1 -> sum=1 cout=1, done one cycle after edge k+1
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      exp1_q.push_back(2'b11);
      @(posedge clk);
      #1 start1 = 1'b0;
      nd = 0;
      for (int i = 1; i <= 10 && nd == 0; i++) begin
         @(negedge clk);
         if (done1) nd = i;
      end
      check("w1_latency", nd, 2);

      repeat (3) @(negedge clk);
      check("w8_queue_drained", exp_q.size(), 0);
      check("w1_queue_drained", exp1_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the half_adder cell.
- Each cycle, two half_adder instances plus an OR gate form one full-adder slice, and a carry flip-flop feeds the carry back in.
- Sits upstream of result consumers and replaces a WIDTH-wide ripple adder where area matters more than latency.
- Uses a start/done handshake and processes operands LSB-first from internal shift registers.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or done.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result of the last completed addition.
- cout  output  1  carry-out of the last completed addition.

Behaviour:
- Reset (asynchronous, rst=1): the following clear immediately and hold while rst=1:
  - state=IDLE;
  - shift registers, bit counter and carry flip-flop = 0;
  - busy=0, done=0, sum=0, cout=0.
- Reset mid-operation aborts the operation. sum/cout clear and no done is produced.
- States:
  - IDLE: busy=0, done=0.
    - On start=1 at edge k: load sa<=a, sb<=b, carry<=cin, cnt<=0, go to SHIFT.
  - SHIFT: busy=1, done=0.
    - Each edge computes s=sa[0]^sb[0]^carry via half_adder pair; c=(sa[0]&sb[0])|((sa[0]^sb[0])&carry).
    - Shifts sa and sb right by 1.
    - Shifts s into the MSB of the accumulator acc.
    - carry<=c; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: sum<={s,acc[WIDTH-1:1]} (full result), cout<=c, go to DONE.
    - start is ignored in SHIFT; no queuing.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 at this edge is accepted exactly as in IDLE (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Latency:
  - start accepted at edge k.
  - Bits are processed on edges k+1 .. k+WIDTH.
  - done=1 and sum/cout valid in the cycle following edge k+WIDTH.
  - Throughput is one addition per WIDTH+1 cycles.
- sum/cout change only on the completing edge (or reset). They hold their value through IDLE and through any subsequent SHIFT until the next completion.
- a, b and cin may change freely after the accepting edge without affecting the result.
- cnt width is clog2(WIDTH)+1.
- WIDTH=1: SHIFT lasts a single edge.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). No overflow flag.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start at edge k:
  - busy=1 for 8 cycles;
  - done pulse one cycle after edge k+8;
  - sum=8'h00, cout=1.
- a=8'h5A, b=8'h33, cin=1 -> sum=8'h8E, cout=0. During SHIFT, sum keeps the previous result (8'h00); cout=1 from the first test is unchanged until the completing edge.
- Start held high continuously with a=8'h01, b=8'h01, cin=0:
  - start during SHIFT is ignored;
  - back-to-back acceptance occurs in the DONE cycle;
  - done pulses every 9 cycles;
  - sum=8'h02 each time.
- Assert rst for 1 cycle at the 4th SHIFT edge of a=8'hF0, b=8'h0F:
  - busy, done, sum and cout drop to 0 immediately;
  - no done follows;
  - the next start with a=8'h10, b=8'h20 gives sum=8'h30.
- Change a/b to 8'hAA/8'h55 one cycle after an accepted start with a=8'h03, b=8'h04, cin=0 -> sum=8'h07 (captured operands used).
- WIDTH=1: a=1, b=1, cin=1 -> done one cycle after edge k+1; sum=1, cout=1.
